div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Sequential signed 32-bit divider that sits directly downstream of the multicycle control unit.
- The control unit pulses DivOp to start an operation and waits for completion.
- The block computes quotient and remainder using MIPS DIV semantics and writes them into the HI/LO path (remainder to HI, quotient to LO).
- It raises a divide-by-zero flag that the control unit routes to its exception mux.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- div_start  in  1  start request (DivOp); sampled only in IDLE.
- dividend  in  WIDTH  signed dividend (A register); sampled on the accepted start edge.
- divisor  in  WIDTH  signed divisor (B register); sampled on the accepted start edge.
- hi_out  out  WIDTH  remainder; registered and held until the next successful completion.
- lo_out  out  WIDTH  quotient; registered and held until the next successful completion.
- div_busy  out  1  high while an operation is in progress.
- div_end  out  1  one-cycle completion pulse; feeds the control unit's end input.
- div_zero  out  1  one-cycle pulse, coincident with div_end, when the divisor was zero.

Behaviour:
- Reset (reset_in=0, any time, including mid-operation):
  - State returns to IDLE.
  - hi_out=0, lo_out=0, div_busy=0, div_end=0, div_zero=0.
  - Counter and internal registers are cleared.
  - Any in-flight operation is discarded with no div_end pulse.
- States: IDLE, DIV, FIN.
- IDLE, div_start=1, divisor!=0:
  - Latch |dividend| into quotient shift register Q and |divisor| into D; clear partial remainder R.
  - Latch sign_q = dividend[WIDTH-1] XOR divisor[WIDTH-1] and sign_r = dividend[WIDTH-1].
  - Counter = WIDTH; div_busy=1; go to DIV.
- IDLE, div_start=1, divisor==0:
  - Stay in IDLE and do not set busy.
  - Assert div_end=1 and div_zero=1 for exactly the next cycle.
  - hi_out/lo_out are unchanged.
- DIV, one restoring step per clock:
  - {R,Q} shifted left by 1.
  - If the shifted R >= D (unsigned, WIDTH+1-bit compare): R -= D and Q[0]=1; otherwise Q[0]=0.
  - Counter decrements; when it reaches 0 after the step, go to FIN.
- FIN:
  - lo_out = sign_q ? -Q : Q; hi_out = sign_r ? -R : R (two's complement, truncated to WIDTH).
  - div_end=1 for this one cycle; div_busy=0 from the following cycle; return to IDLE.
- Latency: start sampled at edge E0 → div_end high in the cycle following edge E0+WIDTH+1 (34 cycles total for WIDTH=32). The divide-by-zero path has a latency of 1.
- div_start while div_busy=1 is ignored. The control unit keeps DivOp as a pulse or level; a level still high in IDLE after FIN starts a new operation.
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo_out=0x80000000, hi_out=0, with no flag (MIPS-defined wrap).
- Operand inputs may change after the start edge without affecting the result.
- div_end and div_zero are never asserted together with div_busy=1.

Decomposition:
- Shared package (cpu_defs):
  - DIV_WIDTH=32.
  - State encodings IDLE=2'b00, DIV=2'b01, FIN=2'b10.
  - The control unit's DivOp/Div-exception mux select constants, so the control unit and div_unit agree.
- One sub-module is natural: div_step, the combinational single restoring iteration. Inputs are R, Q, D; outputs are next R and next Q. It is reused by the planned DIVM path.
- The FSM, counter, and sign fixup stay in div_unit.

Test Plan:
- 7 / 2 → div_end exactly 34 cycles after the start edge; lo_out=0x00000003, hi_out=0x00000001, div_zero=0.
- -7 / 2 (0xFFFFFFF9, 0x00000002) → lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Then 7 / -2 → lo_out=0xFFFFFFFD, hi_out=0x00000001.
- 0x80000000 / 0xFFFFFFFF → lo_out=0x80000000, hi_out=0, div_zero=0. Also check 0x12345678 / 1 → lo_out=0x12345678, hi_out=0.
- 100 / 0 with prior results lo=3, hi=1 → next cycle div_end=1, div_zero=1, div_busy=0; lo_out=3 and hi_out=1 unchanged.
- Start 7/2, pulse div_start with 9/3 at cycle 5 → pulse ignored; result is still lo=3, hi=1 with a single div_end.
- Start 7/2, drop reset_in at cycle 10 → all outputs 0 immediately (asynchronous), no div_end. After release, a 9/3 start gives lo=3, hi=0 at the normal latency.

Source files
------------

// File: rtl/cpu_defs.sv
// Definitions shared between the multicycle control unit and the divider.
package cpu_defs;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        FIN  = 2'b10
    } div_state_e;

    // DivOp encodings driven by the control unit
    localparam logic DIVOP_NONE  = 1'b0;
    localparam logic DIVOP_START = 1'b1;

    // Exception mux selects in the control unit
    localparam logic [1:0] EXC_SEL_NONE     = 2'b00;
    localparam logic [1:0] EXC_SEL_OVF      = 2'b01;
    localparam logic [1:0] EXC_SEL_DIV_ZERO = 2'b10;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration on unsigned magnitudes.
module div_step
    import cpu_defs::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic           ge;

    // Shift {R,Q} left and conditionally subtract the divisor
    always_comb begin
        shifted = {r, q[WIDTH-1]};
        ge      = (shifted >= {1'b0, d});
        r_next  = ge ? WIDTH'(shifted - {1'b0, d}) : shifted[WIDTH-1:0];
        q_next  = {q[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider with MIPS DIV semantics: remainder to HI, quotient to LO.
module div_unit
    import cpu_defs::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_busy,
    output logic             div_end,
    output logic             div_zero
);

    div_state_e       state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic             sign_q;
    logic             sign_r;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (r_nx),
        .q_next (q_nx)
    );

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state    <= IDLE;
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            cnt      <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_busy <= 1'b0;
            div_end  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            div_end  <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_start) begin
                        if (divisor == '0) begin
                            // Zero divisor completes immediately, results untouched
                            div_end  <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            q_q      <= dividend[WIDTH-1] ? -dividend : dividend;
                            d_q      <= divisor[WIDTH-1] ? -divisor : divisor;
                            r_q      <= '0;
                            sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            sign_r   <= dividend[WIDTH-1];
                            cnt      <= CNT_W'(WIDTH);
                            div_busy <= 1'b1;
                            state    <= DIV;
                        end
                    end
                end
                DIV: begin
                    r_q <= r_nx;
                    q_q <= q_nx;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    // Restore signs: quotient by operand XOR, remainder follows dividend
                    lo_out   <= sign_q ? -q_q : q_q;
                    hi_out   <= sign_r ? -r_q : r_q;
                    div_end  <= 1'b1;
                    div_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against a 64-bit arithmetic reference.
module tb_div_unit;

    logic        clk;
    logic        reset_in;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_busy;
    logic        div_end;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    div_unit dut (
        .clk       (clk),
        .reset_in  (reset_in),
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .div_busy  (div_busy),
        .div_end   (div_end),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating signed division done in 64 bits so the overflow case wraps
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
    endfunction

    // Issue one start pulse and wait (bounded) for div_end; lat=-1 on timeout
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic z, output logic busy_at_end);
        @(negedge clk);
        div_start = 1'b1;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        lat = 1;
        while (!div_end && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        z           = div_zero;
        busy_at_end = div_busy;
        if (!div_end) lat = -1;
    endtask

    task automatic test_reset();
        reset_in  = 1'b0;
        div_start = 1'b1;
        dividend  = 32'd7;
        divisor   = 32'd2;
        repeat (3) @(negedge clk);
        checks++;
        if ({hi_out, lo_out, div_busy, div_end, div_zero} !== 67'd0) begin
            failures++;
            $display("FAIL reset_outputs got hi=%h lo=%h busy=%b end=%b zero=%b exp all 0",
                     hi_out, lo_out, div_busy, div_end, div_zero);
        end
        div_start = 1'b0;
        reset_in  = 1'b1;
        @(negedge clk);
        checks++;
        if ({div_busy, div_end} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release got busy=%b end=%b exp 0 0", div_busy, div_end);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic z, b;
        do_op(32'd7, 32'd2, lat, z, b);
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=34", lat);
        end
        checks++;
        if ({lo_out, hi_out, z, b} !== {32'd3, 32'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL basic_result got lo=%h hi=%h zero=%b busy=%b exp lo=3 hi=1 zero=0 busy=0",
                     lo_out, hi_out, z, b);
        end
        @(negedge clk);
        checks++;
        if ({div_end, lo_out, hi_out} !== {1'b0, 32'd3, 32'd1}) begin
            failures++;
            $display("FAIL basic_hold got end=%b lo=%h hi=%h exp end=0 lo=3 hi=1", div_end, lo_out, hi_out);
        end
    endtask

    task automatic test_signs();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [31:0] el [4];
        logic [31:0] eh [4];
        int lat;
        logic z, b;
        ta = '{32'hFFFF_FFF9, 32'd7,        32'h8000_0000, 32'h1234_5678};
        tb = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1};
        el = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h1234_5678};
        eh = '{32'hFFFF_FFFF, 32'd1,        32'd0,         32'd0};
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], lat, z, b);
            checks++;
            if ({lat, lo_out, hi_out, z} !== {34, el[i], eh[i], 1'b0}) begin
                failures++;
                $display("FAIL signs_%0d got lat=%0d lo=%h hi=%h zero=%b exp lat=34 lo=%h hi=%h zero=0",
                         i, lat, lo_out, hi_out, z, el[i], eh[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic z, b;
        do_op(32'd7, 32'd2, lat, z, b);
        do_op(32'd100, 32'd0, lat, z, b);
        checks++;
        if ({lat, z, b} !== {1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL zero_flag got lat=%0d zero=%b busy=%b exp lat=1 zero=1 busy=0", lat, z, b);
        end
        checks++;
        if ({lo_out, hi_out} !== {32'd3, 32'd1}) begin
            failures++;
            $display("FAIL zero_hold got lo=%h hi=%h exp lo=3 hi=1", lo_out, hi_out);
        end
        @(negedge clk);
        checks++;
        if ({div_end, div_zero, div_busy} !== 3'b000) begin
            failures++;
            $display("FAIL zero_pulse got end=%b zero=%b busy=%b exp 0 0 0", div_end, div_zero, div_busy);
        end
    endtask

    task automatic test_busy_ignore();
        int ends  = 0;
        int first = -1;
        @(negedge clk);
        div_start = 1'b1;
        dividend  = 32'd7;
        divisor   = 32'd2;
        @(negedge clk);
        div_start = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            if (div_end) begin
                ends++;
                if (first < 0) first = n;
            end
            if (n == 5) begin
                div_start = 1'b1;
                dividend  = 32'd9;
                divisor   = 32'd3;
            end else if (n == 6) begin
                div_start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if ({ends, first} !== {1, 34}) begin
            failures++;
            $display("FAIL busy_ignore_end got ends=%0d first=%0d exp ends=1 first=34", ends, first);
        end
        checks++;
        if ({lo_out, hi_out} !== {32'd3, 32'd1}) begin
            failures++;
            $display("FAIL busy_ignore_result got lo=%h hi=%h exp lo=3 hi=1", lo_out, hi_out);
        end
    endtask

    task automatic test_reset_mid();
        int ends = 0;
        int lat;
        logic z, b;
        @(negedge clk);
        div_start = 1'b1;
        dividend  = 32'd7;
        divisor   = 32'd2;
        @(negedge clk);
        div_start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_in = 1'b0;
        #1;
        checks++;
        if ({hi_out, lo_out, div_busy, div_end, div_zero} !== 67'd0) begin
            failures++;
            $display("FAIL mid_reset_async got hi=%h lo=%h busy=%b end=%b zero=%b exp all 0",
                     hi_out, lo_out, div_busy, div_end, div_zero);
        end
        repeat (3) @(negedge clk);
        reset_in = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (div_end || div_busy) ends++;
            @(negedge clk);
        end
        checks++;
        if (ends !== 0) begin
            failures++;
            $display("FAIL mid_reset_discard got active_cycles=%0d exp 0", ends);
        end
        do_op(32'd9, 32'd3, lat, z, b);
        checks++;
        if ({lat, lo_out, hi_out, z} !== {34, 32'd3, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset_after got lat=%0d lo=%h hi=%h zero=%b exp lat=34 lo=3 hi=0 zero=0",
                     lat, lo_out, hi_out, z);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, eq, er;
        int ends = 0;
        int e1 = -1;
        int e2 = -1;
        logic ok1 = 1'b0;
        logic ok2 = 1'b0;
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        model(a, b, eq, er);
        @(negedge clk);
        div_start = 1'b1;
        dividend  = a;
        divisor   = b;
        for (int n = 1; n <= 90; n++) begin
            @(negedge clk);
            if (div_end) begin
                ends++;
                if (ends == 1) begin
                    e1  = n;
                    ok1 = ({lo_out, hi_out} === {eq, er});
                end else if (ends == 2) begin
                    e2  = n;
                    ok2 = ({lo_out, hi_out} === {eq, er});
                    div_start = 1'b0;
                end
            end
        end
        div_start = 1'b0;
        checks++;
        if ({ends, e1, e2} !== {2, 34, 68}) begin
            failures++;
            $display("FAIL level_start_timing got ends=%0d e1=%0d e2=%0d exp ends=2 e1=34 e2=68", ends, e1, e2);
        end
        checks++;
        if ({ok1, ok2} !== 2'b11) begin
            failures++;
            $display("FAIL level_start_result got ok1=%b ok2=%b lo=%h hi=%h exp lo=%h hi=%h",
                     ok1, ok2, lo_out, hi_out, eq, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, eq, er, prev_lo, prev_hi;
        int lat;
        logic z, bz;
        prev_lo = '0;
        prev_hi = '0;
        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            if (i > 0 && $urandom_range(0, 4) == 0) begin
                b = 32'd0;
            end else if ($urandom_range(0, 1) == 1) begin
                b = $urandom;
                if (b == 32'd0) b = 32'd5;
            end else begin
                b = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            do_op(a, b, lat, z, bz);
            if (b == 32'd0) begin
                eq = prev_lo;
                er = prev_hi;
            end else begin
                model(a, b, eq, er);
                prev_lo = eq;
                prev_hi = er;
            end
            checks++;
            if ({lat, z, bz, lo_out, hi_out} !== {(b == 32'd0) ? 1 : 34, b == 32'd0, 1'b0, eq, er}) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h got lat=%0d zero=%b busy=%b lo=%h hi=%h exp lo=%h hi=%h",
                         i, a, b, lat, z, bz, lo_out, hi_out, eq, er);
            end
        end
    endtask

    initial begin
        reset_in  = 1'b0;
        div_start = 1'b0;
        dividend  = '0;
        divisor   = '0;
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
